// File: rtl/pcileech_ft245.sv
// ============================================================================
//  Module      : pcileech_ft245
//  Description : Synchronous FT245 (FT2232H 245-sync) pad engine. Moves host
//                bytes from the FT245 bus to dout, and TX FIFO bytes through a
//                4-entry skid buffer onto the bus. Arbitrates the half-duplex
//                bus with alternating RX/TX priority and OE# turnaround.
//                Optional macro PCILEECH_FT245_SIWU_EN enables the SIWU#
//                send-immediate pulse after TX goes idle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcileech_ft245 #(
  parameter int RX_BURST_MAX = 512,
  parameter int SIWU_IDLE    = 64
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire  [7:0] FT245_DATA,
  input  logic       FT245_RXF_N,
  input  logic       FT245_TXE_N,
  output logic       FT245_RD_N,
  output logic       FT245_WR_N,
  output logic       FT245_OE_N,
  output logic       FT245_SIWU_N,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic [7:0] din,
  input  logic       din_empty,
  input  logic       din_wr_en,
  output logic       din_req_data
);

  localparam int BURST_W = $clog2(RX_BURST_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RX_OE  = 3'd1,
    ST_RX_RD  = 3'd2,
    ST_RX_END = 3'd3,
    ST_TX     = 3'd4
  } state_t;

  state_t               r_state;
  logic                 r_rd_n;
  logic                 r_wr_n;
  logic                 r_oe_n;
  logic [7:0]           r_dout;
  logic                 r_dout_valid;
  logic [BURST_W-1:0]   r_burst_cnt;
  logic                 r_last_rx;

  logic [7:0]           r_mem [4];
  logic [1:0]           r_wr_ptr;
  logic [1:0]           r_rd_ptr;
  logic [2:0]           r_count;
  logic                 r_inflight;

  logic                 w_pop;
  logic                 w_push;
  logic [2:0]           w_count_next;
  logic [7:0]           w_head;
  logic                 w_req;
  logic                 w_capture;
  logic                 w_burst_last;

  // A byte leaves the skid only on an edge where the strobe is low and the FTDI accepts it.
  assign w_pop        = (r_state == ST_TX) & ~r_wr_n & ~FT245_TXE_N;
  // Unsolicited writes are still taken, but never past a full buffer.
  assign w_push       = din_wr_en & ((r_count != 3'd4) | w_pop);
  assign w_count_next = r_count + {2'b00, w_push} - {2'b00, w_pop};
  assign w_head       = r_mem[r_rd_ptr];
  // Request only while buffered plus in-flight bytes leave room; held low in reset.
  assign w_req        = ~rst & ~din_empty & (({1'b0, r_count} + {3'b000, r_inflight}) <= 4'd2);
  assign w_capture    = (r_state == ST_RX_RD) & ~r_rd_n & ~FT245_RXF_N;
  assign w_burst_last = (r_burst_cnt == BURST_W'(RX_BURST_MAX - 1));

  // The pad is driven only while a write strobe is active, so never during RX or turnaround.
  assign FT245_DATA   = r_wr_n ? 8'hzz : w_head;

  assign FT245_RD_N   = r_rd_n;
  assign FT245_WR_N   = r_wr_n;
  assign FT245_OE_N   = r_oe_n;
  assign dout         = r_dout;
  assign dout_valid   = r_dout_valid;
  assign din_req_data = w_req;

  // Skid storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Skid pointers, occupancy and outstanding-request tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= 2'd0;
      r_rd_ptr   <= 2'd0;
      r_count    <= 3'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_req;
      r_count    <= w_count_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
    end
  end

  // Bus arbitration FSM with registered strobes and RX capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_rd_n       <= 1'b1;
      r_wr_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_dout       <= 8'h00;
      r_dout_valid <= 1'b0;
      r_burst_cnt  <= '0;
      r_last_rx    <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      if (w_capture) begin
        r_dout       <= FT245_DATA;
        r_dout_valid <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          // RX yields once to pending TX after an RX burst, so neither side starves.
          if (~FT245_RXF_N && !(r_last_rx && (r_count != 3'd0))) begin
            r_state     <= ST_RX_OE;
            r_oe_n      <= 1'b0;
            r_burst_cnt <= '0;
            r_last_rx   <= 1'b1;
          end else if ((r_count != 3'd0) && ~FT245_TXE_N) begin
            // First TX cycle is a turnaround: strobe high, pad still released.
            r_state   <= ST_TX;
            r_last_rx <= 1'b0;
          end
        end
        ST_RX_OE: begin
          r_state <= ST_RX_RD;
          r_rd_n  <= 1'b0;
        end
        ST_RX_RD: begin
          if (w_capture) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
          end
          if (FT245_RXF_N || (w_capture && w_burst_last)) begin
            r_state <= ST_RX_END;
            r_rd_n  <= 1'b1;
            r_oe_n  <= 1'b1;
          end
        end
        ST_RX_END: begin
          r_state <= ST_IDLE;
        end
        ST_TX: begin
          if (r_wr_n) begin
            if ((r_count == 3'd0) || FT245_TXE_N) begin
              r_state <= ST_IDLE;
            end else begin
              r_wr_n <= 1'b0;
            end
          end else if ((w_count_next == 3'd0) || FT245_TXE_N) begin
            // An unaccepted head byte stays in the skid and is retried next burst.
            r_state <= ST_IDLE;
            r_wr_n  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_rd_n  <= 1'b1;
          r_wr_n  <= 1'b1;
          r_oe_n  <= 1'b1;
        end
      endcase
    end
  end

`ifdef PCILEECH_FT245_SIWU_EN
  localparam int IDLE_W = $clog2(SIWU_IDLE + 1);

  logic              r_siwu_n;
  logic              r_siwu_arm;
  logic [IDLE_W-1:0] r_idle_cnt;

  // Arm when a TX burst drains the skid, then pulse SIWU# after a quiet interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_siwu_n   <= 1'b1;
      r_siwu_arm <= 1'b0;
      r_idle_cnt <= '0;
    end else begin
      r_siwu_n <= 1'b1;
      if (w_pop && (w_count_next == 3'd0)) begin
        r_siwu_arm <= 1'b1;
        r_idle_cnt <= '0;
      end else if (din_wr_en) begin
        r_idle_cnt <= '0;
      end else if (r_siwu_arm) begin
        if (r_idle_cnt == IDLE_W'(SIWU_IDLE - 1)) begin
          r_siwu_n   <= 1'b0;
          r_siwu_arm <= 1'b0;
          r_idle_cnt <= '0;
        end else begin
          r_idle_cnt <= r_idle_cnt + 1'b1;
        end
      end
    end
  end

  assign FT245_SIWU_N = r_siwu_n;
`else
  logic w_siwu_idle_unused;
  assign w_siwu_idle_unused = (SIWU_IDLE != 0);
  assign FT245_SIWU_N       = 1'b1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pcileech_ft245.sv
// ============================================================================
//  Module      : tb_pcileech_ft245
//  Description : Self-checking bench for pcileech_ft245. Models the FTDI host
//                and the TX FIFO as byte queues and checks ordering, latency
//                and bus protocol cycle by cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pcileech_ft245;

  localparam int RX_BURST_MAX = 512;
  localparam int SIWU_IDLE    = 64;

  logic       clk = 1'b0;
  logic       rst;
  wire  [7:0] FT245_DATA;
  logic       rxf_n, txe_n;
  wire        rd_n, wr_n, oe_n, siwu_n;
  wire  [7:0] dout;
  wire        dout_valid;
  logic [7:0] din;
  logic       din_empty, din_wr_en;
  wire        din_req_data;
  logic [7:0] host_byte;

  // FTDI drives the pad whenever its output enable is asserted.
  assign FT245_DATA = (oe_n == 1'b0) ? host_byte : 8'hzz;

  always #5 clk = ~clk;

  pcileech_ft245 #(.RX_BURST_MAX(RX_BURST_MAX), .SIWU_IDLE(SIWU_IDLE)) dut (
    .clk(clk), .rst(rst), .FT245_DATA(FT245_DATA),
    .FT245_RXF_N(rxf_n), .FT245_TXE_N(txe_n),
    .FT245_RD_N(rd_n), .FT245_WR_N(wr_n), .FT245_OE_N(oe_n), .FT245_SIWU_N(siwu_n),
    .dout(dout), .dout_valid(dout_valid),
    .din(din), .din_empty(din_empty), .din_wr_en(din_wr_en), .din_req_data(din_req_data)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_src[$];
  logic [7:0] tx_fifo[$];
  logic [7:0] tx_exp[$];
  logic       pend_valid;
  logic [7:0] pend_byte;
  logic       fifo_inflight;
  logic [7:0] fifo_byte;
  int pushes, accepts, rx_caps, cyc;
  int run_len, max_run, acc_run, max_acc_run;
  int rx_stall, tx_stall;
  logic txe_force, rxf_force_hi;
  logic obs_oe, obs_rd, obs_wr;
  int empty_cyc, siwu_lows;
  logic siwu_check_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic reset_model();
    rx_src.delete(); tx_fifo.delete(); tx_exp.delete();
    pend_valid = 1'b0; fifo_inflight = 1'b0; fifo_byte = 8'h00;
    pushes = 0; accepts = 0; rx_caps = 0;
    run_len = 0; max_run = 0; acc_run = 0; max_acc_run = 0;
    siwu_lows = 0; empty_cyc = 0;
  endtask

  // One clock: observe outputs, drive next inputs, predict what the next edge does.
  task automatic step();
    logic [7:0] busv;
    @(negedge clk);
    obs_oe = oe_n; obs_rd = rd_n; obs_wr = wr_n;
    chk("dout_valid", {31'd0, dout_valid}, {31'd0, pend_valid});
    if (pend_valid) chk("dout", {24'd0, dout}, {24'd0, pend_byte});
    run_len = dout_valid ? run_len + 1 : 0;
    if (run_len > max_run) max_run = run_len;
    if (!wr_n) chk("bus_drive_with_oe", {31'd0, oe_n}, 32'd1);
    if (!rd_n) chk("rd_without_oe", {31'd0, oe_n}, 32'd0);
`ifdef PCILEECH_FT245_SIWU_EN
    if (siwu_n == 1'b0) begin
      siwu_lows++;
      if (siwu_check_en) chk("siwu_delay", cyc - empty_cyc, SIWU_IDLE);
    end
`else
    chk("siwu_const", {31'd0, siwu_n}, 32'd1);
`endif
    busv = FT245_DATA;
    din_wr_en = fifo_inflight;
    din       = fifo_byte;
    rxf_n     = (rx_src.size() == 0) || rxf_force_hi || ($urandom_range(0, 99) < rx_stall);
    host_byte = (rx_src.size() != 0) ? rx_src[0] : 8'h00;
    txe_n     = txe_force || ($urandom_range(0, 99) < tx_stall);
    din_empty = (tx_fifo.size() == 0);
    #1;
    pend_valid = (!rd_n && !rxf_n);
    if (pend_valid) begin
      pend_byte = host_byte;
      void'(rx_src.pop_front());
      rx_caps++;
    end
    if (din_wr_en) pushes++;
    if (!wr_n && !txe_n) begin
      accepts++;
      acc_run++;
      if (acc_run > max_acc_run) max_acc_run = acc_run;
      if (tx_exp.size() != 0) chk("tx_byte", {24'd0, busv}, {24'd0, tx_exp.pop_front()});
      else begin
        checks++; errors++;
        $display("FAIL tx_extra_byte actual=%0h required=none", busv);
      end
      if (pushes == accepts) empty_cyc = cyc + 1;
    end else begin
      acc_run = 0;
    end
    chk("skid_le4", {31'd0, (pushes - accepts) <= 4}, 32'd1);
    fifo_inflight = din_req_data;
    if (din_req_data) begin
      if (tx_fifo.size() != 0) fifo_byte = tx_fifo.pop_front();
      else begin
        checks++; errors++;
        $display("FAIL req_while_empty actual=1 required=0");
      end
    end
    cyc++;
  endtask

  typedef struct {
    logic rst_i;
    logic empty_i;
    logic exp_rd_n;
    logic exp_wr_n;
    logic exp_oe_n;
    logic exp_dv;
    logic exp_req;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vt [6];
  logic first_wr;
  logic decided;

  initial begin
    rst = 1'b1; rxf_n = 1'b1; txe_n = 1'b0; din_empty = 1'b1; din_wr_en = 1'b0;
    din = 8'h00; host_byte = 8'h00; cyc = 0;
    rx_stall = 0; tx_stall = 0; txe_force = 1'b0; rxf_force_hi = 1'b0; siwu_check_en = 1'b0;
    reset_model();

    // Reset and idle behaviour, including the request gate.
    vt[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vt[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vt[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vt[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
    vt[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
    vt[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rst = vt[i].rst_i; din_empty = vt[i].empty_i;
      #1;
      chk("vec_rd_n",  {31'd0, rd_n},         {31'd0, vt[i].exp_rd_n});
      chk("vec_wr_n",  {31'd0, wr_n},         {31'd0, vt[i].exp_wr_n});
      chk("vec_oe_n",  {31'd0, oe_n},         {31'd0, vt[i].exp_oe_n});
      chk("vec_dv",    {31'd0, dout_valid},   {31'd0, vt[i].exp_dv});
      chk("vec_req",   {31'd0, din_req_data}, {31'd0, vt[i].exp_req});
      chk("vec_dout",  {24'd0, dout},         {24'd0, vt[i].exp_dout});
      chk("vec_siwu",  {31'd0, siwu_n},       32'd1);
    end
    @(negedge clk); rst = 1'b1; din_empty = 1'b1;
    @(negedge clk); rst = 1'b0;

    // Ten-byte RX burst: OE# at cycle 1, RD# at cycle 2, consecutive bytes.
    reset_model();
    for (int i = 0; i < 10; i++) rx_src.push_back(8'(i));
    step(); chk("idle_oe", {31'd0, obs_oe}, 32'd1);
    step(); chk("oe_cycle1", {31'd0, obs_oe}, 32'd0); chk("rd_cycle1", {31'd0, obs_rd}, 32'd1);
    step(); chk("rd_cycle2", {31'd0, obs_rd}, 32'd0);
    repeat (15) step();
    chk("rx10_drained", rx_src.size(), 32'd0);
    chk("rx10_run", max_run, 32'd10);

    // 600-byte stream split by the burst limit.
    reset_model();
    for (int i = 0; i < 600; i++) rx_src.push_back(8'(i * 7 + 3));
    for (int k = 0; k < 2000 && (rx_src.size() != 0 || pend_valid); k++) step();
    repeat (4) step();
    chk("rx600_count", rx_caps, 32'd600);
    chk("rx600_burst", max_run, RX_BURST_MAX);

    // Three-byte TX burst back-to-back.
    reset_model();
    tx_fifo = '{8'hA1, 8'hA2, 8'hA3}; tx_exp = '{8'hA1, 8'hA2, 8'hA3};
    for (int k = 0; k < 100 && tx_exp.size() != 0; k++) step();
    repeat (4) step();
    chk("tx3_accepts", accepts, 32'd3);
    chk("tx3_run", max_acc_run, 32'd3);
    chk("tx3_drained", tx_exp.size(), 32'd0);

    // TXE# rises while the second byte is on the bus; it must be retried once.
    reset_model();
    tx_fifo = '{8'hB1, 8'hB2, 8'hB3}; tx_exp = '{8'hB1, 8'hB2, 8'hB3};
    for (int k = 0; k < 100 && accepts == 0; k++) step();
    txe_force = 1'b1;
    step(); chk("b2_presented", {31'd0, obs_wr}, 32'd0);
    repeat (3) step();
    txe_force = 1'b0;
    for (int k = 0; k < 100 && tx_exp.size() != 0; k++) step();
    repeat (4) step();
    chk("retry_accepts", accepts, 32'd3);
    chk("retry_drained", tx_exp.size(), 32'd0);

    // RX burst ends with TX pending and RXF# still low: TX must go next.
    reset_model();
    txe_force = 1'b1;
    tx_fifo = '{8'hC1, 8'hC2}; tx_exp = '{8'hC1, 8'hC2};
    for (int i = 0; i < 6; i++) rx_src.push_back(8'hD0 + 8'(i));
    for (int k = 0; k < 50 && rx_caps < 3; k++) step();
    rxf_force_hi = 1'b1; txe_force = 1'b0;
    step();
    rxf_force_hi = 1'b0;
    decided = 1'b0; first_wr = 1'b0;
    for (int k = 0; k < 20 && !decided; k++) begin
      step();
      if (!obs_wr) begin decided = 1'b1; first_wr = 1'b1; end
      else if (!obs_oe) decided = 1'b1;
    end
    chk("tx_after_rx", {31'd0, first_wr}, 32'd1);
    for (int k = 0; k < 200 && (rx_src.size() != 0 || tx_exp.size() != 0 || pend_valid); k++) step();
    repeat (4) step();
    chk("prio_rx_drained", rx_src.size(), 32'd0);
    chk("prio_tx_drained", tx_exp.size(), 32'd0);

    // Asynchronous reset in the middle of an RX burst with bytes held in the skid.
    reset_model();
    txe_force = 1'b1;
    tx_fifo = '{8'hE1, 8'hE2}; tx_exp = '{8'hE1, 8'hE2};
    for (int i = 0; i < 20; i++) rx_src.push_back(8'h40 + 8'(i));
    repeat (8) step();
    @(negedge clk);
    #2 rst = 1'b1; din_empty = 1'b0;
    #1;
    chk("arst_rd_n", {31'd0, rd_n}, 32'd1);
    chk("arst_oe_n", {31'd0, oe_n}, 32'd1);
    chk("arst_wr_n", {31'd0, wr_n}, 32'd1);
    chk("arst_dv", {31'd0, dout_valid}, 32'd0);
    chk("arst_dout", {24'd0, dout}, 32'd0);
    chk("arst_req", {31'd0, din_req_data}, 32'd0);
    reset_model();
    din_empty = 1'b1; din_wr_en = 1'b0; rxf_n = 1'b1;
    @(negedge clk); rst = 1'b0; txe_force = 1'b0;
    repeat (12) step();
    chk("skid_discarded", accepts, 32'd0);

    // Randomised traffic both ways with FTDI flag stalls.
    reset_model();
    rx_stall = 30; tx_stall = 30;
    for (int i = 0; i < 300; i++) begin
      rx_src.push_back(8'($urandom));
      tx_fifo.push_back(8'($urandom));
      tx_exp.push_back(tx_fifo[$]);
    end
    for (int k = 0; k < 20000 &&
         (rx_src.size() != 0 || tx_exp.size() != 0 || pend_valid || fifo_inflight); k++) step();
    rx_stall = 0; tx_stall = 0;
    repeat (6) step();
    chk("rand_rx_count", rx_caps, 32'd300);
    chk("rand_tx_count", accepts, 32'd300);
    chk("rand_tx_drained", tx_exp.size(), 32'd0);

`ifdef PCILEECH_FT245_SIWU_EN
    // Single byte then idle: one SIWU# pulse after the quiet interval.
    reset_model();
    siwu_check_en = 1'b1;
    tx_fifo = '{8'h5A}; tx_exp = '{8'h5A};
    repeat (SIWU_IDLE + 40) step();
    chk("siwu_pulses", siwu_lows, 32'd1);
    siwu_check_en = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
